// File: rtl/keypad_pkg.sv
// Shared sizes, event record and row-scan FSM encoding for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int RW     = $clog2(ROWS);
  localparam int CW     = $clog2(COLS);
  localparam int CODE_W = 4;

  localparam logic [ROWS-1:0] ROW_RESET = 4'b0001;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              press;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  typedef enum logic {
    ST_DRIVE  = 1'b0,
    ST_SAMPLE = 1'b1
  } row_state_e;

  // Index of the lowest set bit; the drain emits columns in ascending order.
  function automatic logic [CW-1:0] lowest_col(input logic [COLS-1:0] mask);
    logic [CW-1:0] idx;
    idx = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (mask[c]) idx = CW'(c);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_if.sv
// Press-event stream between keypad_scan_debounce (master) and its consumer (slave).
interface keypad_scan_debounce_if;
  import keypad_pkg::*;

  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;
  logic              evt_press;

  modport master (output evt_valid, evt_code, evt_press, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_press, output evt_ready);

endinterface

// File: rtl/keypad_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO with no pop is dropped
// and reported through o_ovf_pulse.
module keypad_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_ovf_pulse
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign o_empty     = (r_count == '0);
  assign w_full      = (r_count == (AW+1)'(DEPTH));
  assign w_pop       = i_pop && !o_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_push      = i_push && (!w_full || w_pop);
  assign o_ovf_pulse = i_push && w_full && !w_pop;
  assign o_data      = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage needs no reset; o_data is masked while empty, so stale words never escape.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 key-matrix scanner with per-key debouncers and a buffered key-event stream.
// Define KEYPAD_RELEASE_EVT_EN to also report key releases (evt_press = 0).
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 100,
  parameter int DEB_SCANS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 gclk,
  input  logic                 gresetn,
  input  logic [COLS-1:0]      KeyX,
  output logic [ROWS-1:0]      KeyY,
  output logic [ROWS*COLS-1:0] key_state,
  keypad_scan_debounce_if.master evt,
  output logic                 scan_frame,
  output logic                 evt_ovf,
  input  logic                 ovf_clr
);

  localparam int             DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DWELL_PRE  = DW'(SCAN_DIV - 2);
  localparam logic [3:0]     DEB_LAST   = 4'(DEB_SCANS - 1);

  logic [COLS-1:0]            r_keyx_meta;
  logic [COLS-1:0]            r_keyx_sync;

  row_state_e                 r_state;
  logic [DW-1:0]              r_dwell;
  logic [ROWS-1:0]            r_key_y;
  logic [RW-1:0]              r_row;
  logic                       r_scan_frame;
  logic [ROWS*COLS-1:0]       r_key_state;
  logic [ROWS*COLS-1:0][3:0]  r_deb_cnt;
  logic [COLS-1:0]            r_pend;
  logic [RW-1:0]              r_pend_row;
  logic                       r_evt_ovf;

  logic [COLS-1:0]            w_row_state;
  logic [COLS-1:0]            w_flip;
  logic [COLS-1:0]            w_report;
  logic [COLS-1:0][3:0]       w_next_cnt;
  logic                       w_push_req;
  logic [CW-1:0]              w_pend_col;
  evt_t                       w_push_evt;
  evt_t                       w_head;
  logic                       w_empty;
  logic                       w_ovf_pulse;

  always_ff @(posedge gclk or negedge gresetn) begin
    if (!gresetn) begin
      r_keyx_meta <= '0;
      r_keyx_sync <= '0;
    end else begin
      r_keyx_meta <= KeyX;
      r_keyx_sync <= r_keyx_meta;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_row_state = '0;
    w_flip      = '0;
    w_next_cnt  = '0;
    for (int c = 0; c < COLS; c++) begin
      w_row_state[c] = r_key_state[{r_row, c[CW-1:0]}];
      if (r_keyx_sync[c] != w_row_state[c]) begin
        if (r_deb_cnt[{r_row, c[CW-1:0]}] == DEB_LAST) w_flip[c] = 1'b1;
        else w_next_cnt[c] = r_deb_cnt[{r_row, c[CW-1:0]}] + 1'b1;
      end
    end
  end

`ifdef KEYPAD_RELEASE_EVT_EN
  assign w_report = w_flip;
`else
  // Only 0->1 flips are reported; a flipping key whose old state was 0 is a press.
  assign w_report = w_flip & ~w_row_state;
`endif

  assign w_push_req      = |r_pend;
  assign w_pend_col      = lowest_col(r_pend);
  assign w_push_evt.code = {r_pend_row, w_pend_col};
`ifdef KEYPAD_RELEASE_EVT_EN
  assign w_push_evt.press = r_key_state[{r_pend_row, w_pend_col}];
`else
  assign w_push_evt.press = 1'b1;
`endif

  // Row scanner, debouncer state and pending drain share one clocked FSM.
  always_ff @(posedge gclk or negedge gresetn) begin
    if (!gresetn) begin
      r_state      <= ST_DRIVE;
      r_dwell      <= '0;
      r_key_y      <= ROW_RESET;
      r_row        <= '0;
      r_scan_frame <= 1'b0;
      r_key_state  <= '0;
      r_deb_cnt    <= '0;
      r_pend       <= '0;
      r_pend_row   <= '0;
    end else begin
      r_scan_frame <= 1'b0;
      unique case (r_state)
        ST_DRIVE: begin
          if (r_dwell == DWELL_PRE) r_state <= ST_SAMPLE;
          r_dwell <= r_dwell + 1'b1;
          if (w_push_req) r_pend[w_pend_col] <= 1'b0;
        end
        ST_SAMPLE: begin
          r_state      <= ST_DRIVE;
          r_dwell      <= '0;
          r_key_y      <= {r_key_y[ROWS-2:0], r_key_y[ROWS-1]};
          r_row        <= r_row + 1'b1;
          r_scan_frame <= r_key_y[ROWS-1];
          r_pend       <= w_report;
          r_pend_row   <= r_row;
          for (int c = 0; c < COLS; c++) begin
            r_deb_cnt[{r_row, c[CW-1:0]}]   <= w_next_cnt[c];
            r_key_state[{r_row, c[CW-1:0]}] <= w_row_state[c] ^ w_flip[c];
          end
        end
        default: r_state <= ST_DRIVE;
      endcase
    end
  end

  keypad_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk         (gclk),
    .rst_n       (gresetn),
    .i_push      (w_push_req),
    .i_data      (w_push_evt),
    .i_pop       (evt.evt_ready),
    .o_data      (w_head),
    .o_empty     (w_empty),
    .o_ovf_pulse (w_ovf_pulse)
  );

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge gclk or negedge gresetn) begin
    if (!gresetn)         r_evt_ovf <= 1'b0;
    else if (w_ovf_pulse) r_evt_ovf <= 1'b1;
    else if (ovf_clr)     r_evt_ovf <= 1'b0;
  end

  assign KeyY          = r_key_y;
  assign key_state     = r_key_state;
  assign scan_frame    = r_scan_frame;
  assign evt_ovf       = r_evt_ovf;
  assign evt.evt_valid = !w_empty;
  assign evt.evt_code  = w_head.code;
  assign evt.evt_press = w_head.press;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Self-checking bench: cycle-indexed behavioural model of scan, debounce and event queue,
// directed scenarios with literal expectations, then a randomized soak.
`timescale 1ns/1ps
module tb_keypad_scan_debounce;
  import keypad_pkg::*;

  localparam int SD    = 8;
  localparam int DEB   = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 4 * SD;

  logic        gclk    = 1'b0;
  logic        gresetn = 1'b0;
  logic [3:0]  KeyX    = '0;
  logic [3:0]  KeyY;
  logic [15:0] key_state;
  logic        scan_frame;
  logic        evt_ovf;
  logic        ovf_clr = 1'b0;

  keypad_scan_debounce_if evt_if ();

  always #5 gclk = ~gclk;

  keypad_scan_debounce #(
    .SCAN_DIV   (SD),
    .DEB_SCANS  (DEB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .gclk       (gclk),
    .gresetn    (gresetn),
    .KeyX       (KeyX),
    .KeyY       (KeyY),
    .key_state  (key_state),
    .evt        (evt_if),
    .scan_frame (scan_frame),
    .evt_ovf    (evt_ovf),
    .ovf_clr    (ovf_clr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int t; evt_t e; } sched_t;

  int          m_n;
  logic [3:0]  m_hist[$];
  logic [15:0] m_ks;
  int          m_cnt[16];
  evt_t        m_fifo[$];
  sched_t      m_sched[$];
  bit          m_ovf;

  task automatic m_reset();
    m_n = 0;
    m_hist.delete();
    m_ks = '0;
    for (int k = 0; k < 16; k++) m_cnt[k] = 0;
    m_fifo.delete();
    m_sched.delete();
    m_ovf = 1'b0;
  endtask

  task automatic m_compare();
    logic [3:0] exp_y;
    exp_y = 4'b0001 << ((m_n / SD) % 4);
    check("KeyY", KeyY, exp_y);
    check("key_state", key_state, m_ks);
    check("scan_frame", scan_frame, (m_n > 0 && m_n % FRAME == 0));
    check("evt_valid", evt_if.evt_valid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      check("evt_code", evt_if.evt_code, m_fifo[0].code);
      check("evt_press", evt_if.evt_press, m_fifo[0].press);
    end
    check("evt_ovf", evt_ovf, m_ovf);
  endtask

  task automatic m_step();
    logic [3:0] samp;
    int row, k, j;
    bit drop;
    evt_t e;
    sched_t s;
    m_hist.push_back(KeyX);
    if (m_hist.size() > 3) void'(m_hist.pop_front());
    samp = (m_hist.size() == 3) ? m_hist[0] : 4'b0000;
    if (m_fifo.size() > 0 && evt_if.evt_ready) void'(m_fifo.pop_front());
    drop = 1'b0;
    if (m_sched.size() > 0 && m_sched[0].t == m_n) begin
      s = m_sched.pop_front();
      if (m_fifo.size() < DEPTH) m_fifo.push_back(s.e);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (m_n % SD == SD - 1) begin
      row = (m_n / SD) % 4;
      j = 0;
      for (int c = 0; c < 4; c++) begin
        k = row * 4 + c;
        if (samp[c] == m_ks[k]) m_cnt[k] = 0;
        else begin
          m_cnt[k]++;
          if (m_cnt[k] >= DEB) begin
            m_ks[k] = ~m_ks[k];
            m_cnt[k] = 0;
`ifdef KEYPAD_RELEASE_EVT_EN
            if (1'b1) begin
`else
            if (m_ks[k]) begin
`endif
              e.code  = 4'(k);
              e.press = m_ks[k];
              s.t = m_n + 1 + j;
              s.e = e;
              m_sched.push_back(s);
              j++;
            end
          end
        end
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge gclk);
      if (!gresetn) m_reset();
      else begin
        m_compare();
        m_step();
        m_n++;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] pressed = '0;
  int          cyc = 0;
  int          noise_pct = 0;

  task automatic drive_keyx();
    int row;
    logic [3:0] v;
    row = (cyc / SD) % 4;
    v = pressed[row*4 +: 4];
    for (int c = 0; c < 4; c++)
      if (noise_pct > 0 && $urandom_range(0, 99) < noise_pct) v[c] = ~v[c];
    KeyX = v;
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
    cyc++;
    drive_keyx();
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic release_reset();
    pressed = '0;
    KeyX = '0;
    noise_pct = 0;
    ovf_clr = 1'b0;
    evt_if.evt_ready = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    gresetn = 1'b1;
    cyc = 0;
    drive_keyx();
  endtask

  task automatic do_reset();
    #2 gresetn = 1'b0;
    release_reset();
  endtask

  initial begin
    int idx;
    evt_if.evt_ready = 1'b0;
    do_reset();

    // Scan rotation and press of key 6 with back-pressure.
    pressed[6] = 1'b1;
    check("rst evt_valid", evt_if.evt_valid, 1'b0);
    check("rst evt_code", evt_if.evt_code, 4'h0);
    check("rst evt_press", evt_if.evt_press, 1'b0);
    check("rst key_state", key_state, 16'h0000);
    run_to(7);   check("row0 dwell KeyY", KeyY, 4'b0001);
    run_to(8);   check("row1 KeyY", KeyY, 4'b0010);
    run_to(16);  check("row2 KeyY", KeyY, 4'b0100);
    run_to(24);  check("row3 KeyY", KeyY, 4'b1000);
    run_to(32);  check("wrap KeyY", KeyY, 4'b0001);
                 check("frame pulse", scan_frame, 1'b1);
    run_to(33);  check("frame one cycle", scan_frame, 1'b0);
    run_to(47);  check("key6 before 2nd sample", key_state, 16'h0000);
    run_to(48);  check("key6 after 2nd sample", key_state, 16'h0040);
    run_to(49);  check("key6 evt_valid", evt_if.evt_valid, 1'b1);
                 check("key6 evt_code", evt_if.evt_code, 4'd6);
                 check("key6 evt_press", evt_if.evt_press, 1'b1);
    run_to(60);  check("key6 held valid", evt_if.evt_valid, 1'b1);
    evt_if.evt_ready = 1'b1;
    tick();      check("key6 popped", evt_if.evt_valid, 1'b0);
    run_to(140); check("key6 single event", evt_if.evt_valid, 1'b0);

    // Key 6 alternating on successive row-1 samples never settles.
    do_reset();
    evt_if.evt_ready = 1'b1;
    pressed[6] = 1'b1;
    while (cyc < 130) begin
      pressed[6] = (((cyc + 1) / FRAME) % 2 == 0);
      tick();
    end
    check("bounce key_state", key_state, 16'h0000);
    check("bounce no event", evt_if.evt_valid, 1'b0);

    // Row 3 fills the FIFO; one more press overflows.
    do_reset();
    pressed[15:12] = 4'hF;
    drive_keyx();
    run_to(64);
    pressed[0] = 1'b1;
    drive_keyx();
    run_to(68);  check("fill evt_code", evt_if.evt_code, 4'd12);
                 check("fill no ovf", evt_ovf, 1'b0);
    run_to(104); check("pre-drop ovf", evt_ovf, 1'b0);
    run_to(105); check("drop sets ovf", evt_ovf, 1'b1);
    run_to(110);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf cleared", evt_ovf, 1'b0);
    check("head kept", evt_if.evt_code, 4'd12);
    evt_if.evt_ready = 1'b1;
    tick();      check("second code", evt_if.evt_code, 4'd13);
    run_to(130);

    // Press then release key 0.
    do_reset();
    evt_if.evt_ready = 1'b1;
    pressed[0] = 1'b1;
    drive_keyx();
    run_to(41);  check("key0 press valid", evt_if.evt_valid, 1'b1);
                 check("key0 press code", evt_if.evt_code, 4'd0);
                 check("key0 press bit", evt_if.evt_press, 1'b1);
    run_to(50);
    pressed[0] = 1'b0;
    drive_keyx();
    run_to(105); check("key0 released", key_state, 16'h0000);
`ifdef KEYPAD_RELEASE_EVT_EN
    check("release valid", evt_if.evt_valid, 1'b1);
    check("release code", evt_if.evt_code, 4'd0);
    check("release bit", evt_if.evt_press, 1'b0);
`else
    check("no release evt", evt_if.evt_valid, 1'b0);
`endif
    run_to(110);

    // Asynchronous reset mid-drain with three events queued.
    do_reset();
    pressed[7:4] = 4'hF;
    drive_keyx();
    run_to(51);  check("queued before reset", evt_if.evt_valid, 1'b1);
    #2 gresetn = 1'b0;
    #1;
    check("async rst evt_valid", evt_if.evt_valid, 1'b0);
    check("async rst key_state", key_state, 16'h0000);
    check("async rst KeyY", KeyY, 4'b0001);
    release_reset();
    run_to(20);

    // Randomized soak with bounce noise, back-pressure windows and random clears.
    do_reset();
    noise_pct = 4;
    while (cyc < 4000) begin
      if ($urandom_range(0, 29) == 0) begin
        idx = $urandom_range(0, 15);
        pressed[idx] = ~pressed[idx];
      end
      evt_if.evt_ready = ((cyc / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 19) == 0);
      ovf_clr = ($urandom_range(0, 59) == 0);
      tick();
    end

    @(negedge gclk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Upstream stage of the 16-bit GPIO input word on the Cortex-M3 system; drives the 4x4 key-matrix rows (KeyY) and samples the columns (KeyX).
- Produces a debounced 16-bit key-state word that is wired directly to gpioin.
- Produces a press-event stream with a valid/ready handshake, buffered in a small FIFO, so firmware no longer polls raw, bouncing levels.
- Runs on the 27 MHz board clock.

Parameters:
- SCAN_DIV, 100, gclk cycles each row is driven before its columns are sampled; legal range 8..65535.
- DEB_SCANS, 4, consecutive disagreeing samples of one key required to flip its debounced state; legal range 1..15.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, minimum 2.

Ports:
- gclk  in  1  27 MHz clock.
- gresetn  in  1  asynchronous active-low reset.
- KeyX  in  4  column inputs; asynchronous; 1 = key closed on the driven row.
- KeyY  out  4  one-hot row drive.
- key_state  out  16  debounced state; bits [4r+3:4r] = row r, bit 4r+c = column c.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts the head.
- evt_code  out  4  key index 4r+c of the head event.
- evt_press  out  1  1 = press, 0 = release.
- scan_frame  out  1  one-cycle pulse after the row-3 sample.
- evt_ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears evt_ovf.

Behaviour:
- Reset (asynchronous):
  - KeyY=4'b0001; key_state=0; all debounce counters=0.
  - Dwell counter=0; pending mask=0; FIFO empty; evt_valid=0; evt_code=0; evt_press=0; scan_frame=0; evt_ovf=0.
  - A reset asserted mid-scan or mid-drain discards all state, including pending events.
- KeyX passes through a 2-flop synchronizer before any use.
- Row FSM (states DRIVE, SAMPLE):
  - DRIVE: dwell counts 0..SCAN_DIV-2 with KeyY held.
  - SAMPLE: one cycle at dwell=SCAN_DIV-1. Captures the synchronized KeyX for the current row and updates that row's 4 debouncers. KeyY rotates left (0001->0010->0100->1000->0001) on the following edge. Dwell returns to 0 and the FSM re-enters DRIVE.
  - scan_frame pulses in the cycle after a SAMPLE of row 3.
- Debouncer, one per key, counter width 4:
  - If sample == state, counter=0.
  - Otherwise, if counter == DEB_SCANS-1, state flips, counter=0 and the key's pending bit is set; else counter increments.
  - Effective latency is DEB_SCANS row-3-relative frames plus synchronizer delay.
- Pending drain:
  - The 4-bit pending mask for the sampled row is loaded at SAMPLE.
  - Starting the next cycle, one event per cycle is pushed, lowest column first, with code = 4r+c and press = new state.
  - The drain completes within 4 cycles; SCAN_DIV>=8 guarantees it finishes before the next SAMPLE.
- Release events are pushed only when the optional feature is compiled in; otherwise release bits are dropped from the mask.
- FIFO:
  - First-word-fall-through: evt_valid = !empty; a pop occurs on evt_valid & evt_ready.
  - Push and pop in the same cycle when full: the pop completes and the push is accepted, no overflow.
  - Push when full with no pop: the event is dropped and evt_ovf is set.
  - ovf_clr clears evt_ovf; if a drop occurs in the same cycle, the set wins.
- key_state is updated at SAMPLE, independently of FIFO state; it is never blocked by back-pressure.

Optional Feature:
- Macro KEYPAD_RELEASE_EVT_EN.
- Defined: 1->0 transitions push events with evt_press=0.
- Undefined: only presses are pushed; evt_press is tied to 1 and the release-event logic is removed.

Decomposition:
- Shared package keypad_pkg holds:
  - Row count (4) and column count (4).
  - Key-code width (4).
  - The event struct type {code[3:0], press}.
  - One-hot row reset constant 4'b0001.
- Sub-module keypad_evt_fifo: generic FWFT FIFO parameterized by FIFO_DEPTH and the event width; it generates full/empty and the overflow pulse.
- Scanner, synchronizer and debouncers stay in the top block.

Test Plan:
1. Reset released, SCAN_DIV=8: KeyY=0001 for 8 cycles, then 0010, 0100, 1000, back to 0001; scan_frame pulses once every 32 cycles.
2. DEB_SCANS=2, key 6 (row 1, col 2) held closed: key_state[6]=1 after the second row-1 SAMPLE; exactly one event, code=6, press=1; evt_valid stays high until evt_ready.
3. Key 6 bounces 1,0,1,0 on alternate row-1 samples: key_state[6] stays 0 and no event is produced.
4. Keys 12..15 closed simultaneously, evt_ready=0, FIFO_DEPTH=4: events are pushed in order 12, 13, 14, 15 with no overflow. One more press then sets evt_ovf=1; ovf_clr clears it.
5. With KEYPAD_RELEASE_EVT_EN: press then release key 0 gives events {0,1} then {0,0}. Without the macro, only {0,1} appears.
6. gresetn pulsed low mid-drain with 3 events queued: evt_valid=0, key_state=0 and KeyY=0001 immediately, asynchronously.
